ecc_encoder: RTL
================

// Module: ecc_encoder
// PURPOSE
//  Write-side partner of ecc_decoder: accepts one page of 8 x 16-bit words, forwards each word with its
//  batch index to the SRAM write port, and accumulates the 8-bit check code over the page.
//  Sits between the ingress page assembler and SRAM. Emits the code with the 8th word so data and code
//  are written in the same cycle. Code bit equations match ecc_decoder's cur_code exactly.
// PARAMETERS
//  DATA_W      16  word width; only 16 supported
//  PAGE_WORDS   8  words per page; only 8 supported (batch index is 3 bits)
//  CODE_W       8  check-code width
// PORTS
//  clk            in   1   clock; single clock domain
//  rst_n          in   1   asynchronous active-low reset
//  in_valid       in   1   input word valid
//  in_ready       out  1   block can accept a word this cycle
//  in_data        in   16  input word
//  page_abort     in   1   drop current partial page; accumulator and batch counter cleared
//  out_valid      out  1   out_data/out_batch valid for SRAM write
//  out_ready      in   1   downstream accepts output this cycle
//  out_batch      out  3   index of out_data within page, 0..7
//  out_data       out  16  word forwarded unmodified
//  end_of_page    out  1   high with out_batch==7; out_code valid in that beat only
//  out_code       out  8   check code of the completed page
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_batch=0, out_data=0, end_of_page=0, out_code=0, batch counter=0,
//    accumulator=0. in_ready=1 out of reset.
//  - Single output register stage: in_ready = ~out_valid | out_ready. Input beat accepted when
//    in_valid & in_ready; output beat consumed when out_valid & out_ready. Latency 1 cycle, full throughput.
//  - On accepted beat: out_data<=in_data, out_batch<=batch counter, out_valid<=1, counter<=counter+1
//    (wraps 7->0). Without acceptance but with consumption: out_valid<=0. Stalled output holds all fields.
//  - Contribution c(w,b) of word w at batch b (all XOR reductions):
//    c[0]=^w[{0,2,4,6,8,10,12,14}]  c[1]=^w[{1,2,5,6,9,10,13,14}]  c[2]=^w[{3,4,5,6,11,12,13,14}]
//    c[3]=^w[14:7]   (all four for every b)
//    c[4]: b odd -> ^w[14:0];  b in {0,2,4,6} -> w[15]
//    c[5]: b in {2,3,6,7} -> ^w[14:0];  b in {1,2,5,6} -> w[15]  (both XORed when both apply)
//    c[6]: b in {4,5,6,7} -> ^w[14:0];  b in {3,4,5,6} -> w[15]
//    c[7]: b==7 -> w[15]; else 0
//  - Accumulator acc XORs c(in_data,counter) on each accepted beat with counter 0..6. On accepted beat with
//    counter==7: out_code<=acc^c(in_data,7), end_of_page<=1, acc<=0. Any other accepted beat: end_of_page<=0.
//  - page_abort (sync, highest priority): counter<=0, acc<=0; a beat offered the same cycle is NOT accepted
//    (in_ready forced 0). An output beat already registered is still presented and must drain normally.
//  - Reset mid-page discards the partial page; next accepted word is batch 0.
//  - out_code holds its value until the next page completes; consumers use it only while end_of_page=1.
// STRUCTURE
//  - ecc_pkg: ECC_DATA_W, ECC_PAGE_WORDS, ECC_CODE_W, typedefs ecc_word_t/ecc_code_t/ecc_batch_t,
//    15-bit masks for code bits 0..3, batch-membership masks for code bits 4..6; shared with ecc_decoder.
//  - Sub-module ecc_word_parity (combinational): (word, batch) -> 8-bit contribution c. Top holds
//    handshake, counter, accumulator, output register.
// TESTING
//  - All-zero page, no stalls -> 8 beats, out_batch 0..7, end_of_page on beat 7 only, out_code=8'h00.
//  - Word0=16'h0001, rest 0 -> 8'h01; word0=16'h8000 -> 8'h10; word7=16'h8000 -> 8'h80.
//  - Word7=16'h0001 -> 8'h71; word3=16'h0040 -> 8'h37; random page encoded, fed to ecc_decoder with one
//    bit flipped in words 0..6 bits 0..3 -> corrected data equals original.
//  - out_ready low 3 cycles mid-page -> in_ready=0, outputs held stable, no beat lost/duplicated, code unchanged.
//  - page_abort after batch 4, then full page of 16'hFFFF -> batches restart at 0, code equals fresh-page golden.
//  - rst_n asserted asynchronously mid-page -> outputs zero immediately; next page batch 0, correct code.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared ECC definitions for the page encoder/decoder pair: widths, types and code-bit masks.
package ecc_pkg;

  localparam int unsigned ECC_DATA_W     = 16;
  localparam int unsigned ECC_PAGE_WORDS = 8;
  localparam int unsigned ECC_CODE_W     = 8;
  localparam int unsigned ECC_BATCH_W    = 3;
  localparam int unsigned ECC_LOW_W      = ECC_DATA_W - 1;

  typedef logic [ECC_DATA_W-1:0]  ecc_word_t;
  typedef logic [ECC_CODE_W-1:0]  ecc_code_t;
  typedef logic [ECC_BATCH_W-1:0] ecc_batch_t;

  // Bit-position masks over w[14:0] for code bits 0..3 (same for every batch)
  localparam logic [ECC_LOW_W-1:0] ECC_C0_MASK = 15'h5555;  // {0,2,4,...,14}
  localparam logic [ECC_LOW_W-1:0] ECC_C1_MASK = 15'h6666;  // {1,2,5,6,9,10,13,14}
  localparam logic [ECC_LOW_W-1:0] ECC_C2_MASK = 15'h7878;  // {3,4,5,6,11,12,13,14}
  localparam logic [ECC_LOW_W-1:0] ECC_C3_MASK = 15'h7F80;  // {7..14}

  // Batch-membership masks: PAR selects ^w[14:0], MSB selects w[15]
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C4_PAR_MASK = 8'hAA;  // odd batches
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C4_MSB_MASK = 8'h55;  // even batches
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C5_PAR_MASK = 8'hCC;  // {2,3,6,7}
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C5_MSB_MASK = 8'h66;  // {1,2,5,6}
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C6_PAR_MASK = 8'hF0;  // {4,5,6,7}
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C6_MSB_MASK = 8'h78;  // {3,4,5,6}
  localparam logic [ECC_PAGE_WORDS-1:0] ECC_C7_MSB_MASK = 8'h80;  // {7}

  // Registered SRAM write beat
  typedef struct packed {
    ecc_batch_t batch;
    ecc_word_t  data;
    logic       end_of_page;
    ecc_code_t  code;
  } ecc_out_beat_t;

endpackage

// File: rtl/ecc_encoder_if.sv
// Word-in / SRAM-write-out handshake bundle of the page ECC encoder.
interface ecc_encoder_if;
  import ecc_pkg::*;

  logic       in_valid;
  logic       in_ready;
  ecc_word_t  in_data;
  logic       page_abort;
  logic       out_valid;
  logic       out_ready;
  ecc_batch_t out_batch;
  ecc_word_t  out_data;
  logic       end_of_page;
  ecc_code_t  out_code;

  // Encoder side
  modport slave (
    input  in_valid, in_data, page_abort, out_ready,
    output in_ready, out_valid, out_batch, out_data, end_of_page, out_code
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_data, page_abort, out_ready,
    input  in_ready, out_valid, out_batch, out_data, end_of_page, out_code
  );

endinterface

// File: rtl/ecc_word_parity.sv
// Combinational contribution of one word at a given batch index to the page check code.
module ecc_word_parity
  import ecc_pkg::*;
(
  input  ecc_word_t  word,
  input  ecc_batch_t batch,
  output ecc_code_t  contrib_c
);

  logic [ECC_LOW_W-1:0] low;
  logic                 par;
  logic                 msb;

  // Bits 0..3 depend only on the word; bits 4..7 mix low parity and MSB by batch
  always_comb begin
    low       = word[ECC_LOW_W-1:0];
    par       = ^low;
    msb       = word[ECC_DATA_W-1];
    contrib_c = '0;
    contrib_c[0] = ^(low & ECC_C0_MASK);
    contrib_c[1] = ^(low & ECC_C1_MASK);
    contrib_c[2] = ^(low & ECC_C2_MASK);
    contrib_c[3] = ^(low & ECC_C3_MASK);
    contrib_c[4] = (par & ECC_C4_PAR_MASK[batch]) ^ (msb & ECC_C4_MSB_MASK[batch]);
    contrib_c[5] = (par & ECC_C5_PAR_MASK[batch]) ^ (msb & ECC_C5_MSB_MASK[batch]);
    contrib_c[6] = (par & ECC_C6_PAR_MASK[batch]) ^ (msb & ECC_C6_MSB_MASK[batch]);
    contrib_c[7] = msb & ECC_C7_MSB_MASK[batch];
  end

endmodule

// File: rtl/ecc_encoder.sv
// Page ECC encoder: forwards words with batch index and emits the page code alongside word 7.
module ecc_encoder
  import ecc_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  ecc_encoder_if.slave  bus
);

  logic          out_valid_q;
  ecc_out_beat_t out_q;
  ecc_batch_t    cnt_q;
  ecc_code_t     acc_q;

  ecc_code_t     contrib_c;
  logic          in_ready_c;
  logic          accept_c;
  logic          consume_c;
  logic          last_c;

  ecc_word_parity u_parity (
    .word      (bus.in_data),
    .batch     (cnt_q),
    .contrib_c (contrib_c)
  );

  // Abort blocks the input so a page never straddles an abort
  assign in_ready_c = ~bus.page_abort & (~out_valid_q | bus.out_ready);
  assign accept_c   = bus.in_valid & in_ready_c;
  assign consume_c  = out_valid_q & bus.out_ready;
  assign last_c     = (cnt_q == ECC_BATCH_W'(ECC_PAGE_WORDS - 1));

  assign bus.in_ready    = in_ready_c;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_batch   = out_q.batch;
  assign bus.out_data    = out_q.data;
  assign bus.end_of_page = out_q.end_of_page;
  assign bus.out_code    = out_q.code;

  // Single output register stage; holds all fields while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (accept_c) begin
      out_valid_q       <= 1'b1;
      out_q.batch       <= cnt_q;
      out_q.data        <= bus.in_data;
      out_q.end_of_page <= last_c;
      if (last_c) begin
        out_q.code <= acc_q ^ contrib_c;
      end
    end else if (consume_c) begin
      out_valid_q <= 1'b0;
    end
  end

  // Batch counter and running code accumulator; abort wins over acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (bus.page_abort) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else if (accept_c) begin
      cnt_q <= cnt_q + ECC_BATCH_W'(1);
      acc_q <= last_c ? '0 : (acc_q ^ contrib_c);
    end
  end

endmodule
